fir_mac_scheduler: RTL

Time-multiplexed FIR controller that shares one N-bit multiply-accumulate path across NTAPS coefficients instead of instantiating one multiplier per tap. It accepts samples over the same valid-style handshake as the dataflow operators and keeps a circular sample history. For each accepted sample it sequences NTAPS multiply-accumulate steps and presents the filtered result until it is acknowledged. Coefficients are runtime-configurable through a small write port; it sits between the sample source and the downstream consumer, in place of the fully parallel filter when area matters more than throughput.

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_mac_scheduler_if.sv | 32 +++
 rtl/fir_sample_ring.sv | 48 ++++
 rtl/fir_mac_scheduler.sv | 110 +++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the time-multiplexed FIR MAC scheduler.
package fir_pkg;

  localparam int unsigned FIR_N     = 16;
  localparam int unsigned FIR_NTAPS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } fir_state_e;

  function automatic int unsigned fir_aw(input int unsigned ntaps);
    return $clog2(ntaps);
  endfunction

  // Coefficient bank value after reset: tap k holds k+1.
  function automatic int unsigned coef_default(input int unsigned k);
    return k + 1;
  endfunction

endpackage

// File: rtl/fir_mac_scheduler_if.sv
// Sample/result handshake and coefficient write port of the FIR scheduler.
interface fir_mac_scheduler_if
  import fir_pkg::*;
#(
  parameter int unsigned N     = FIR_N,
  parameter int unsigned NTAPS = FIR_NTAPS,
  parameter int unsigned AW    = fir_aw(NTAPS)
);

  logic          rin;
  logic [N-1:0]  dataIn1;
  logic          ready;
  logic          r_out;
  logic [N-1:0]  dataOut1;
  logic          out_ack;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [N-1:0]  coef_data;
  logic          cfg_err;
  logic          busy;

  modport master (
    output rin, dataIn1, out_ack, coef_we, coef_addr, coef_data,
    input  ready, r_out, dataOut1, cfg_err, busy
  );

  modport slave (
    input  rin, dataIn1, out_ack, coef_we, coef_addr, coef_data,
    output ready, r_out, dataOut1, cfg_err, busy
  );

endinterface

// File: rtl/fir_sample_ring.sv
// Circular sample history with write pointer and a read port relative to the newest sample.
module fir_sample_ring
  import fir_pkg::*;
#(
  parameter int unsigned N     = FIR_N,
  parameter int unsigned NTAPS = FIR_NTAPS,
  parameter int unsigned AW    = fir_aw(NTAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [N-1:0]  wr_data,
  input  logic [AW-1:0] rd_k,
  output logic [N-1:0]  rd_data
);

  logic [N-1:0]  ring_q [NTAPS];
  logic [N-1:0]  ring_d [NTAPS];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_idx_c;

  always_comb begin
    ring_d   = ring_q;
    wr_ptr_d = wr_ptr_q;
    if (wr_en) begin
      ring_d[wr_ptr_q] = wr_data;
      wr_ptr_d = (32'(wr_ptr_q) == NTAPS - 1) ? '0 : wr_ptr_q + AW'(1);
    end
  end

  // Newest sample sits one slot behind the write pointer.
  always_comb begin
    rd_idx_c = AW'((32'(wr_ptr_q) + 2 * NTAPS - 1 - 32'(rd_k)) % NTAPS);
  end

  assign rd_data = ring_q[rd_idx_c];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      for (int unsigned i = 0; i < NTAPS; i++) ring_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      ring_q   <= ring_d;
    end
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// FIR controller sharing one multiply-accumulate path across all taps, one step per cycle.
module fir_mac_scheduler
  import fir_pkg::*;
#(
  parameter int unsigned N     = FIR_N,
  parameter int unsigned NTAPS = FIR_NTAPS,
  parameter int unsigned AW    = fir_aw(NTAPS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  fir_mac_scheduler_if.slave  bus
);

  fir_state_e    state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  dout_q, dout_d;
  logic [AW-1:0] k_q, k_d;
  logic [N-1:0]  coef_q [NTAPS];
  logic [N-1:0]  coef_d [NTAPS];
  logic          r_out_q, r_out_d;
  logic          cfg_err_q, cfg_err_d;

  logic          idle_c, accept_c, addr_ok_c, coef_wr_c;
  logic [N-1:0]  hist_c, prod_c;

  assign idle_c    = (state_q == ST_IDLE);
  assign accept_c  = enable & idle_c & bus.rin;
  assign addr_ok_c = 32'(bus.coef_addr) < NTAPS;
  assign coef_wr_c = enable & idle_c & bus.coef_we & addr_ok_c;

  fir_sample_ring #(.N(N), .NTAPS(NTAPS), .AW(AW)) u_ring (
    .clk     (clk),
    .rst_n   (rst),
    .wr_en   (accept_c),
    .wr_data (bus.dataIn1),
    .rd_k    (k_q),
    .rd_data (hist_c)
  );

  // Product truncated to N bits before accumulation; both wrap modulo 2^N.
  assign prod_c = N'(coef_q[k_q] * hist_c);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    k_d       = k_q;
    dout_d    = dout_q;
    r_out_d   = r_out_q;
    cfg_err_d = 1'b0;
    coef_d    = coef_q;
    if (enable) begin
      cfg_err_d = bus.coef_we & ~coef_wr_c;
      if (coef_wr_c) coef_d[bus.coef_addr] = bus.coef_data;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.rin) begin
            acc_d   = '0;
            k_d     = '0;
            state_d = ST_MAC;
          end
        end
        ST_MAC: begin
          acc_d = acc_q + prod_c;
          k_d   = k_q + AW'(1);
          if (32'(k_q) == NTAPS - 1) begin
            k_d     = '0;
            dout_d  = acc_d;
            r_out_d = 1'b1;
            state_d = ST_OUT;
          end
        end
        ST_OUT: begin
          if (bus.out_ack) begin
            r_out_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      k_q       <= '0;
      dout_q    <= '0;
      r_out_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      for (int unsigned i = 0; i < NTAPS; i++) coef_q[i] <= N'(coef_default(i));
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      dout_q    <= dout_d;
      r_out_q   <= r_out_d;
      cfg_err_q <= cfg_err_d;
      coef_q    <= coef_d;
    end
  end

  assign bus.ready    = enable & idle_c;
  assign bus.busy     = ~idle_c;
  assign bus.r_out    = r_out_q;
  assign bus.dataOut1 = dout_q;
  assign bus.cfg_err  = cfg_err_q;

endmodule
